// File: rtl/aplic_msi_notifier.sv
// rtl/aplic_msi_notifier.sv - APLIC MSI delivery stage: round-robin source arbitration, genmsi injection, MSI write handshake
module aplic_msi_notifier #(
   parameter int NR_SRC = 32,
   parameter int SRC_W  = $clog2(NR_SRC)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_domaincfg_ie,
   input  logic [NR_SRC-1:0] i_pending,
   input  logic [NR_SRC-1:0] i_enabled,
   output logic              o_tgt_rd_en,
   output logic [SRC_W-1:0]  o_tgt_rd_idx,
   input  logic [31:0]       i_tgt_rd_data,
   input  logic [43:0]       i_msi_base_ppn,
   input  logic [2:0]        i_lhxs,
   input  logic              i_genmsi_wr,
   input  logic [13:0]       i_genmsi_hi,
   input  logic [10:0]       i_genmsi_eiid,
   output logic              o_genmsi_busy,
   output logic              o_clr_pending,
   output logic [SRC_W-1:0]  o_clr_idx,
   output logic              o_msi_valid,
   input  logic              i_msi_ready,
   output logic [55:0]       o_msi_addr,
   output logic [31:0]       o_msi_data
);

   typedef enum logic [1:0] {IDLE, RD_TGT, SEND, GEN_SEND} state_t;

   state_t            state, state_d;
   logic [SRC_W-1:0]  rr_ptr, cur_idx, sel_hi, sel_lo, sel, next_ptr;
   logic              found_hi;
   logic [13:0]       tgt_hi, gen_hi, a_hi;
   logic [5:0]        tgt_gi, a_gi;
   logic [10:0]       tgt_eiid, gen_eiid, a_eiid;
   logic              gen_busy;
   logic              load_cur, adv_ptr, gen_done;
   logic [43:0]       ppn_or;
   logic [NR_SRC-1:0] cand;
   logic              tgt_unused;

   assign cand       = i_pending & i_enabled & {{(NR_SRC-1){1'b1}}, 1'b0};
   assign tgt_unused = i_tgt_rd_data[11];

   // Lowest set candidate at or above rr_ptr, falling back to the lowest set candidate overall (wrap).
   always_comb begin
      sel_hi   = '0;
      sel_lo   = '0;
      found_hi = 1'b0;
      for (int i = NR_SRC - 1; i >= 1; i--) begin
         if (cand[i]) begin
            sel_lo = SRC_W'(i);
            if (SRC_W'(i) >= rr_ptr) begin
               sel_hi   = SRC_W'(i);
               found_hi = 1'b1;
            end
         end
      end
   end

   assign sel      = found_hi ? sel_hi : sel_lo;
   assign next_ptr = (cur_idx == SRC_W'(NR_SRC - 1)) ? SRC_W'(1) : cur_idx + SRC_W'(1);

   always_comb begin
      state_d       = state;
      o_tgt_rd_en   = 1'b0;
      o_tgt_rd_idx  = '0;
      o_msi_valid   = 1'b0;
      o_clr_pending = 1'b0;
      o_clr_idx     = '0;
      load_cur      = 1'b0;
      adv_ptr       = 1'b0;
      gen_done      = 1'b0;
      a_hi          = '0;
      a_gi          = '0;
      a_eiid        = '0;
      case (state)
         IDLE: begin
            if (gen_busy) begin
               state_d = GEN_SEND;
            end else if (!i_rst && i_domaincfg_ie && (|cand)) begin
               load_cur     = 1'b1;
               o_tgt_rd_en  = 1'b1;
               o_tgt_rd_idx = sel;
               state_d      = RD_TGT;
            end
         end
         RD_TGT: begin
            state_d = (cand[cur_idx] && i_domaincfg_ie) ? SEND : IDLE;
         end
         SEND: begin
            a_hi        = tgt_hi;
            a_gi        = tgt_gi;
            a_eiid      = tgt_eiid;
            o_msi_valid = |tgt_eiid;
            // An eiid of 0 suppresses the write but still retires the source.
            if (!o_msi_valid || i_msi_ready) begin
               o_clr_pending = 1'b1;
               o_clr_idx     = cur_idx;
               adv_ptr       = 1'b1;
               state_d       = IDLE;
            end
         end
         GEN_SEND: begin
            a_hi        = gen_hi;
            a_eiid      = gen_eiid;
            o_msi_valid = 1'b1;
            if (i_msi_ready) begin
               gen_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ppn_or        = i_msi_base_ppn | ({30'd0, a_hi} << i_lhxs) | {38'd0, a_gi};
   assign o_msi_addr    = o_msi_valid ? {ppn_or, 12'h000} : 56'd0;
   assign o_msi_data    = o_msi_valid ? {21'd0, a_eiid} : 32'd0;
   assign o_genmsi_busy = gen_busy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         rr_ptr   <= SRC_W'(1);
         cur_idx  <= '0;
         tgt_hi   <= '0;
         tgt_gi   <= '0;
         tgt_eiid <= '0;
         gen_busy <= 1'b0;
         gen_hi   <= '0;
         gen_eiid <= '0;
      end else begin
         state <= state_d;
         if (load_cur) cur_idx <= sel;
         if (state == RD_TGT) begin
            tgt_hi   <= i_tgt_rd_data[31:18];
            tgt_gi   <= i_tgt_rd_data[17:12];
            tgt_eiid <= i_tgt_rd_data[10:0];
         end
         if (adv_ptr) rr_ptr <= next_ptr;
         if (gen_done) begin
            gen_busy <= 1'b0;
         end else if (i_genmsi_wr && !gen_busy) begin
            gen_busy <= 1'b1;
            gen_hi   <= i_genmsi_hi;
            gen_eiid <= i_genmsi_eiid;
         end
      end
   end

endmodule
